ubuf_port_scheduler: RTL and testbench

- Controller that shares one simple-dual-port unified buffer BRAM between two write clients and two burst-read clients.
- Write port clients: host loader (W0) and systolic-array result writeback (W1). Round-robin, single beat.
- Read port clients: SA operand feeder (R0) and host readback (R1). Round-robin, non-preemptive bursts with address generation.
- Sits between the host/SA interfaces and the BRAM instance. BRAM writes and reads on negedge clk; this block works on posedge.

---
 rtl/ubuf_port_scheduler_pkg.sv | 24 ++
 rtl/ubuf_port_scheduler_rr_arb2.sv | 35 +++
 rtl/ubuf_port_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ubuf_port_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ubuf_port_scheduler_pkg.sv
// Shared definitions for the unified-buffer port scheduler: the address-width helper,
// the read FSM state encodings and the client IDs.
package ubuf_port_scheduler_pkg;

  // Number of bits needed to hold the value (0 for 0).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  localparam logic RD_IDLE  = 1'b0;
  localparam logic RD_BURST = 1'b1;

  localparam logic CLI_0 = 1'b0;
  localparam logic CLI_1 = 1'b1;

endpackage

// File: rtl/ubuf_port_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester wins outright; on contention the
// client not granted last wins. The last-grant record moves only when advance is high.
module ubuf_port_scheduler_rr_arb2
  import ubuf_port_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_q == CLI_1) ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // Reset to "client 1 served last" so client 0 is favoured first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= CLI_1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ubuf_port_scheduler.sv
// Shares one simple-dual-port BRAM between two single-beat writers and two burst readers.
// Define UBUF_SCHED_FWD_EN to forward same-cycle write data to a colliding read beat.
module ubuf_port_scheduler
  import ubuf_port_scheduler_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 128,
  parameter int unsigned RAM_DEPTH  = 256,
  parameter int unsigned ADDR_WIDTH = clogb2(RAM_DEPTH - 1),
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [RAM_WIDTH-1:0]  w0_data,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [RAM_WIDTH-1:0]  w1_data,
  input  logic                  r0_req,
  output logic                  r0_ack,
  input  logic [ADDR_WIDTH-1:0] r0_base,
  input  logic [LEN_WIDTH-1:0]  r0_len,
  input  logic                  r1_req,
  output logic                  r1_ack,
  input  logic [ADDR_WIDTH-1:0] r1_base,
  input  logic [LEN_WIDTH-1:0]  r1_len,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic                  rd_last,
  output logic [RAM_WIDTH-1:0]  rd_data,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [RAM_WIDTH-1:0]  bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [RAM_WIDTH-1:0]  bram_doutb
);

  logic [1:0] wr_req, wr_gnt;
  logic [1:0] rd_req, rd_gnt;
  logic       rd_advance;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  owner_q, owner_d;
  logic [1:0]            ack_q, ack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_id_q, rd_id_d;
  logic                  rd_last_q, rd_last_d;
  logic [RAM_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  fwd_hit;

  // Write side: the pointer only moves when both writers compete.
  assign wr_req = {w1_valid, w0_valid};

  ubuf_port_scheduler_rr_arb2 u_wr_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (wr_req),
    .advance (&wr_req),
    .grant   (wr_gnt)
  );

  assign w0_ready   = wr_gnt[0];
  assign w1_ready   = wr_gnt[1];
  assign bram_wea   = |wr_req;
  assign bram_addra = wr_gnt[1] ? w1_addr : w0_addr;
  assign bram_dina  = wr_gnt[1] ? w1_data : w0_data;

  // A request already acked this cycle must not be granted again while its owner drops it.
  assign rd_req = {r1_req & ~ack_q[1], r0_req & ~ack_q[0]};

  // The read pointer is recorded at grant time; it is only consulted in RD_IDLE, so this
  // is indistinguishable from advancing it when the burst completes.
  assign rd_advance = (state_q == RD_IDLE) && (rd_req != 2'b00);

  ubuf_port_scheduler_rr_arb2 u_rd_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (rd_req),
    .advance (rd_advance),
    .grant   (rd_gnt)
  );

  assign sel_len = rd_gnt[1] ? r1_len : r0_len;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    owner_d    = owner_q;
    ack_d      = 2'b00;
    bram_enb   = 1'b0;
    bram_addrb = '0;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_id_d    = rd_id_q;
    rd_data_d  = rd_data_q;
    fwd_hit    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_advance) begin
          ack_d      = rd_gnt;
          owner_d    = rd_gnt[1];
          cur_addr_d = rd_gnt[1] ? r1_base : r0_base;
          remain_d   = sel_len;
          if (sel_len != '0) begin
            state_d = RD_BURST;
          end
        end
      end
      RD_BURST: begin
        bram_enb   = 1'b1;
        bram_addrb = cur_addr_q;
        cur_addr_d = (cur_addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;
        remain_d   = remain_q - 1'b1;
        rd_valid_d = 1'b1;
        rd_id_d    = owner_q;
        rd_last_d  = (remain_q == LEN_WIDTH'(1));
`ifdef UBUF_SCHED_FWD_EN
        fwd_hit    = bram_wea && (bram_addra == cur_addr_q);
`endif
        rd_data_d  = fwd_hit ? bram_dina : bram_doutb;
        if (remain_q == LEN_WIDTH'(1)) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RD_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      owner_q    <= CLI_0;
      ack_q      <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      owner_q    <= owner_d;
      ack_q      <= ack_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ubuf_port_scheduler.sv
// Self-checking bench for ubuf_port_scheduler: behavioural BRAM, expected-beat queues built
// from a memory model, and a negedge compare process on the read path.
module tb_ubuf_port_scheduler;

  localparam int W = 128;
  localparam int D = 256;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           w0_valid = 0, w1_valid = 0;
  logic           w0_ready, w1_ready;
  logic [7:0]     w0_addr = 0, w1_addr = 0;
  logic [W-1:0]   w0_data = 0, w1_data = 0;
  logic           r0_req = 0, r1_req = 0;
  logic           r0_ack, r1_ack;
  logic [7:0]     r0_base = 0, r1_base = 0;
  logic [8:0]     r0_len = 0, r1_len = 0;
  logic           rd_valid, rd_id, rd_last;
  logic [W-1:0]   rd_data;
  logic           bram_wea, bram_enb;
  logic [7:0]     bram_addra, bram_addrb;
  logic [W-1:0]   bram_dina, bram_doutb;

  always #5 clk = ~clk;

  ubuf_port_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .w0_valid   (w0_valid),
    .w0_ready   (w0_ready),
    .w0_addr    (w0_addr),
    .w0_data    (w0_data),
    .w1_valid   (w1_valid),
    .w1_ready   (w1_ready),
    .w1_addr    (w1_addr),
    .w1_data    (w1_data),
    .r0_req     (r0_req),
    .r0_ack     (r0_ack),
    .r0_base    (r0_base),
    .r0_len     (r0_len),
    .r1_req     (r1_req),
    .r1_ack     (r1_ack),
    .r1_base    (r1_base),
    .r1_len     (r1_len),
    .rd_valid   (rd_valid),
    .rd_id      (rd_id),
    .rd_last    (rd_last),
    .rd_data    (rd_data),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_enb   (bram_enb),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  function automatic logic [W-1:0] init_val(input int i);
    return {64'hFACE_0000_0000_0000, 64'(i)};
  endfunction

  // Read-first BRAM on negedge.
  logic [W-1:0] mem [D];
  initial begin
    bram_doutb = '0;
    for (int i = 0; i < D; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (bram_enb) bram_doutb <= mem[bram_addrb];
      if (bram_wea) mem[bram_addra] <= bram_dina;
    end
  end

  typedef struct {
    logic         id;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  int           nchecks = 0;
  int           nerrors = 0;
  logic [W-1:0] model_mem [D];
  logic         wlast = 1'b1;
  logic         rlast = 1'b1;
  logic [7:0]   exp_addrs [$];
  beat_t        exp_beats [$];
  logic [7:0]   obs_addrs [$];
  logic [W-1:0] last_data;
  beat_t        cur_b;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bram_enb) begin
      obs_addrs.push_back(bram_addrb);
      if (exp_addrs.size() == 0) begin
        nchecks++; nerrors++;
        $display("FAIL unexpected_enb: got addr %0d expected no read", bram_addrb);
      end else begin
        chk("bram_addrb", W'(bram_addrb), W'(exp_addrs.pop_front()));
      end
    end
    if (rd_valid) begin
      last_data = rd_data;
      if (exp_beats.size() == 0) begin
        nchecks++; nerrors++;
        $display("FAIL unexpected_beat: got rd_valid data %0h expected none", rd_data);
      end else begin
        cur_b = exp_beats.pop_front();
        chk("rd_id", W'(rd_id), W'(cur_b.id));
        chk("rd_last", W'(rd_last), W'(cur_b.last));
        chk("rd_data", rd_data, cur_b.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic v0, input logic [7:0] a0, input logic [W-1:0] d0,
                          input logic v1, input logic [7:0] a1, input logic [W-1:0] d1);
    logic g0, g1;
    w0_valid = v0; w0_addr = a0; w0_data = d0;
    w1_valid = v1; w1_addr = a1; w1_data = d1;
    #1;
    g0 = v0 && (!v1 || wlast);
    g1 = v1 && !g0;
    chk("w0_ready", W'(w0_ready), W'(g0));
    chk("w1_ready", W'(w1_ready), W'(g1));
    chk("bram_wea", W'(bram_wea), W'(v0 | v1));
    if (g0 || g1) begin
      chk("bram_addra", W'(bram_addra), W'(g0 ? a0 : a1));
      chk("bram_dina", bram_dina, g0 ? d0 : d1);
      model_mem[g0 ? a0 : a1] = g0 ? d0 : d1;
    end
    if (v0 && v1) wlast = g1;
    tick();
    w0_valid = 0;
    w1_valid = 0;
  endtask

  task automatic push_burst(input logic id, input logic [7:0] base, input logic [8:0] len);
    int a;
    for (int k = 0; k < int'(len); k++) begin
      a = (int'(base) + k) % D;
      exp_addrs.push_back(8'(a));
      exp_beats.push_back('{id, (k == int'(len) - 1), model_mem[a]});
    end
  endtask

  task automatic run_reqs(input logic do0, input logic [7:0] b0, input logic [8:0] l0,
                          input logic do1, input logic [7:0] b1, input logic [8:0] l1,
                          output int c0, output int c1);
    logic p0, p1, exp_id, id;
    p0 = do0; p1 = do1; c0 = -1; c1 = -1;
    r0_req = do0; r0_base = b0; r0_len = l0;
    r1_req = do1; r1_base = b1; r1_len = l1;
    for (int n = 1; n <= 60 && (p0 || p1); n++) begin
      exp_id = (p0 && p1) ? ~rlast : p1;
      tick();
      if (r0_ack || r1_ack) begin
        id = r1_ack;
        chk("ack_winner", W'({r1_ack, r0_ack}), W'(exp_id ? 2'b10 : 2'b01));
        rlast = id;
        if (id) begin
          push_burst(1'b1, b1, l1); p1 = 0; r1_req = 0; c1 = n;
        end else begin
          push_burst(1'b0, b0, l0); p0 = 0; r0_req = 0; c0 = n;
        end
      end
    end
    if (p0 || p1) begin
      nchecks++; nerrors++;
      $display("FAIL ack_timeout: got no ack (pending %0b%0b) expected ack", p1, p0);
      r0_req = 0; r1_req = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_addrs.size() != 0 || exp_beats.size() != 0); i++) tick();
    repeat (2) tick();
    chk("drain_addrs", W'(exp_addrs.size()), '0);
    chk("drain_beats", W'(exp_beats.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] coll_exp;

  initial begin
    int c0, c1;
    for (int i = 0; i < D; i++) model_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", W'({w0_ready, w1_ready, r0_ack, r1_ack, rd_valid, rd_id, rd_last,
                          bram_wea, bram_enb, bram_addra, bram_addrb}), '0);
    chk("reset_rd_data", rd_data, '0);
    reset_n = 1'b1;
    tick();

    // Single write then a one-beat readback.
    do_write(1, 8'd5, W'(128'hAA), 0, 8'd0, '0);
    run_reqs(1, 8'd5, 9'd1, 0, 8'd0, 9'd0, c0, c1);
    chk("r0_ack_latency", W'(c0), W'(1));
    drain();
    chk("rd_data_literal_AA", last_data, W'(128'hAA));

    do_write(0, 8'd0, '0, 1, 8'd9, W'(128'h99));

    // Contested writes starting from reset pointer.
    for (int i = 0; i < 4; i++)
      do_write(1, 8'(20 + i), W'(128'hA0 + i), 1, 8'(30 + i), W'(128'hB0 + i));
    chk("mem20", mem[20], W'(128'hA0));
    chk("mem31", mem[31], W'(128'hB1));
    chk("mem22", mem[22], W'(128'hA2));
    chk("mem33", mem[33], W'(128'hB3));
    chk("mem9", mem[9], W'(128'h99));

    // Wrapping burst from R1.
    obs_addrs.delete();
    run_reqs(0, 8'd0, 9'd0, 1, 8'(D - 2), 9'd4, c0, c1);
    drain();
    chk("wrap_count", W'(obs_addrs.size()), W'(4));
    if (obs_addrs.size() == 4)
      chk("wrap_addrs", W'({obs_addrs[0], obs_addrs[1], obs_addrs[2], obs_addrs[3]}),
          W'(32'hFEFF_0001));

    // Both readers together: R0 (R1 served last) then R1 after one idle cycle.
    run_reqs(1, 8'd0, 9'd3, 1, 8'd10, 9'd2, c0, c1);
    chk("conc_r0_ack", W'(c0), W'(1));
    chk("conc_r1_ack", W'(c1), W'(5));
    drain();

    // Write/read collision on address 7.
    do_write(1, 8'd7, W'(128'h11), 0, 8'd0, '0);
`ifdef UBUF_SCHED_FWD_EN
    coll_exp = W'(128'h55);
`else
    coll_exp = W'(128'h11);
`endif
    r0_req = 1; r0_base = 8'd6; r0_len = 9'd2;
    tick();
    chk("coll_ack", W'(r0_ack), W'(1));
    r0_req = 0;
    rlast = 1'b0;
    exp_addrs.push_back(8'd6);
    exp_addrs.push_back(8'd7);
    exp_beats.push_back('{1'b0, 1'b0, model_mem[6]});
    exp_beats.push_back('{1'b0, 1'b1, coll_exp});
    tick();
    do_write(1, 8'd7, W'(128'h55), 0, 8'd0, '0);
    drain();
    chk("coll_data", last_data, coll_exp);

    // Reset during the second beat of a long burst.
    r0_req = 1; r0_base = 8'd40; r0_len = 9'd8;
    tick();
    chk("long_ack", W'(r0_ack), W'(1));
    r0_req = 0;
    exp_addrs.push_back(8'd40);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", W'({r0_ack, r1_ack, rd_valid, rd_id, rd_last, bram_enb, bram_addrb}),
        '0);
    chk("midreset_rd_data", rd_data, '0);
    wlast = 1'b1;
    rlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    run_reqs(1, 8'd3, 9'd0, 0, 8'd0, 9'd0, c0, c1);
    chk("len0_ack", W'(c0), W'(1));
    repeat (4) tick();
    drain();
    chk("len0_no_valid", W'(rd_valid), '0);

    // Write pointer back to favouring W0 after reset.
    do_write(1, 8'd50, W'(128'hC0), 1, 8'd51, W'(128'hC1));
    chk("mem50", mem[50], W'(128'hC0));

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
